// File: rtl/pim_matmul_unit_pkg.sv
// Shared types for the PIM matrix-multiply responder: sizes, flat matrix type and FSM states.
package types;
  localparam int WIDTH       = 32;
  localparam int MATRIX_SIZE = 4;
  localparam int LEN         = MATRIX_SIZE * MATRIX_SIZE;

  // Row-major flat matrix: element [r][c] lives at index r*MATRIX_SIZE+c.
  typedef logic [LEN-1:0][WIDTH-1:0] matrix_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } pim_mm_state_t;
endpackage

// File: rtl/pim_matmul_unit_if.sv
// Memory-side/compute-side bus of the start/result_ready matrix-multiply handshake.
interface pim_matmul_unit_if #(
  parameter int WIDTH       = types::WIDTH,
  parameter int MATRIX_SIZE = types::MATRIX_SIZE,
  parameter int CYC_W       = 16
);
  localparam int LEN = MATRIX_SIZE * MATRIX_SIZE;

  // start is a one-cycle request taken only when the unit is idle; operands are valid
  // in that cycle alone. result_ready pulses once per accepted start, and result is
  // only meaningful on that pulse. busy spans accept edge through the completion cycle.
  logic                      start;
  logic [LEN-1:0][WIDTH-1:0] matrix_A;
  logic [LEN-1:0][WIDTH-1:0] matrix_B;
  logic [LEN-1:0][WIDTH-1:0] result;
  logic                      result_ready;
  logic                      busy;
  logic [CYC_W-1:0]          compute_cycles;

  modport master (
    output start, matrix_A, matrix_B,
    input  result, result_ready, busy, compute_cycles
  );

  modport slave (
    input  start, matrix_A, matrix_B,
    output result, result_ready, busy, compute_cycles
  );
endinterface

// File: rtl/pim_matmul_unit_mac.sv
// Combinational multiply-accumulate: sum = acc + a*b, everything modulo 2^WIDTH.
module pim_mac #(
  parameter int WIDTH = types::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] sum
);
  logic [WIDTH-1:0] prod;

  assign prod = a * b;
  assign sum  = acc + prod;
endmodule

// File: rtl/pim_matmul_unit.sv
// Matrix-multiply responder: captures A/B on start, computes A x B with one time-shared MAC.
// Optional build macro PIM_SPARSE_SKIP_EN skips k-steps whose A element is zero.
module pim_matmul_unit
  import types::*;
#(
  parameter int WIDTH       = types::WIDTH,
  parameter int MATRIX_SIZE = types::MATRIX_SIZE,
  parameter int CYC_W       = 16
) (
  input  logic           clk,
  input  logic           rst,
  pim_matmul_unit_if.slave bus,
  output pim_mm_state_t  dbg_state
);
  localparam int N     = MATRIX_SIZE;
  localparam int LEN   = N * N;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int LEN_W = (LEN > 1) ? $clog2(LEN) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  pim_mm_state_t             state_q, state_d;
  logic [LEN-1:0][WIDTH-1:0] a_q, b_q, res_q;
  idx_t                      i_q, j_q, k_q;
  idx_t                      i_nxt, j_nxt;
  idx_t                      k_step, k_first_row, k_first_acc;
  logic [WIDTH-1:0]          acc_q, sum;
  logic [CYC_W-1:0]          cnt_q, cyc_q;
  logic                      busy_q;
  logic                      last_k, last_elem, j_wrap;
  logic [LEN_W-1:0]          a_idx, b_idx, r_idx;

  assign a_idx = LEN_W'(i_q) * LEN_W'(N) + LEN_W'(k_q);
  assign b_idx = LEN_W'(k_q) * LEN_W'(N) + LEN_W'(j_q);
  assign r_idx = LEN_W'(i_q) * LEN_W'(N) + LEN_W'(j_q);

  pim_mac #(.WIDTH(WIDTH)) u_mac (
    .a   (a_q[a_idx]),
    .b   (b_q[b_idx]),
    .acc (acc_q),
    .sum (sum)
  );

  assign j_wrap    = (j_q == idx_t'(N - 1));
  assign j_nxt     = j_wrap ? '0 : j_q + idx_t'(1);
  assign i_nxt     = j_wrap ? i_q + idx_t'(1) : i_q;
  assign last_elem = (i_q == idx_t'(N - 1)) && j_wrap;

`ifdef PIM_SPARSE_SKIP_EN
  logic [N-1:0][N-1:0] mask_q, mask_in;
  logic [IDX_W:0]      nxt_in_row;

  // Lowest set bit of m at or above lo; returns N when there is none.
  function automatic logic [IDX_W:0] find_set(input logic [N-1:0] m, input int lo);
    find_set = (IDX_W + 1)'(N);
    for (int b = N - 1; b >= 0; b--)
      if (b >= lo && m[b]) find_set = (IDX_W + 1)'(b);
  endfunction

  // An all-zero row still gets one step at k=0, where A is zero, so it writes 0.
  function automatic idx_t first_k(input logic [N-1:0] m);
    logic [IDX_W:0] f;
    f = find_set(m, 0);
    first_k = (f >= (IDX_W + 1)'(N)) ? '0 : f[IDX_W-1:0];
  endfunction

  always_comb begin
    mask_in = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        mask_in[r][c] = |bus.matrix_A[r*N+c];
  end

  always_ff @(posedge clk) begin
    if (rst)                               mask_q <= '0;
    else if (state_q == IDLE && bus.start) mask_q <= mask_in;
  end

  assign nxt_in_row  = find_set(mask_q[i_q], int'(k_q) + 1);
  assign last_k      = (nxt_in_row >= (IDX_W + 1)'(N));
  assign k_step      = nxt_in_row[IDX_W-1:0];
  assign k_first_row = first_k(mask_q[i_nxt]);
  assign k_first_acc = first_k(mask_in[0]);
`else
  assign last_k      = (k_q == idx_t'(N - 1));
  assign k_step      = k_q + idx_t'(1);
  assign k_first_row = '0;
  assign k_first_acc = '0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = MAC;
      MAC:     if (last_k && last_elem) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (bus.start) begin
          a_q    <= bus.matrix_A;
          b_q    <= bus.matrix_B;
          i_q    <= '0;
          j_q    <= '0;
          k_q    <= k_first_acc;
          acc_q  <= '0;
          cnt_q  <= '0;
          busy_q <= 1'b1;
        end
        MAC: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          if (last_k) begin
            res_q[r_idx] <= sum;
            acc_q        <= '0;
            k_q          <= k_first_row;
            j_q          <= j_nxt;
            i_q          <= i_nxt;
          end else begin
            acc_q <= sum;
            k_q   <= k_step;
          end
        end
        DONE: begin
          cyc_q  <= cnt_q;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result         = res_q;
  assign bus.result_ready   = (state_q == DONE);
  assign bus.busy           = busy_q;
  assign bus.compute_cycles = cyc_q;
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_pim_matmul_unit.sv
// Bench for pim_matmul_unit: directed vector table, hand-written corner sequences, random ops.
module tb_pim_matmul_unit;
  import types::*;

  localparam int N     = MATRIX_SIZE;
  localparam int LIMIT = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  pim_mm_state_t dbg_state;

  pim_matmul_unit_if bus ();

  pim_matmul_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string   name;
    matrix_t a;
    matrix_t b;
    matrix_t exp;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_mat(input string name, input matrix_t act, input matrix_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int e = 0; e < LEN; e++)
        if (act[e] !== exp[e]) begin
          $display("FAIL %s: elem %0d got %h want %h", name, e, act[e], exp[e]);
          break;
        end
    end
  endtask

  // Reference product with wrap-around arithmetic on WIDTH-bit words.
  function automatic matrix_t ref_mm(input matrix_t a, input matrix_t b);
    matrix_t res;
    logic [WIDTH-1:0] s, p;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = '0;
        for (int k = 0; k < N; k++) begin
          p = a[r*N+k] * b[k*N+c];
          s = s + p;
        end
        res[r*N+c] = s;
      end
    return res;
  endfunction

  function automatic int exp_cycles(input matrix_t a);
    int cyc, pc;
    cyc = 0;
`ifdef PIM_SPARSE_SKIP_EN
    for (int r = 0; r < N; r++) begin
      pc = 0;
      for (int c = 0; c < N; c++) if (a[r*N+c] != 0) pc++;
      cyc += N * ((pc == 0) ? 1 : pc);
    end
`else
    pc  = 0;
    cyc = N * N * N + pc;
`endif
    return cyc;
  endfunction

  function automatic matrix_t rand_mat(input bit sparse);
    matrix_t m;
    for (int e = 0; e < LEN; e++) begin
      m[e] = $urandom;
      if (sparse && $urandom_range(0, 1) == 0) m[e] = '0;
    end
    if (sparse && $urandom_range(0, 2) == 0)
      for (int c = 0; c < N; c++) m[$urandom_range(0, N - 1)*N+c] = '0;
    return m;
  endfunction

  // One operation: start pulse, then observe cycle by cycle (index 1 = cycle after accept).
  task automatic run_op(input matrix_t a, input matrix_t b, input int repulse_at,
                        input bit repulse_done, input bit chk_hold, input matrix_t hold_exp,
                        output matrix_t res, output int ready_idx, output int ready_cnt,
                        output int busy_cnt, output bit timed_out);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.matrix_A = a;
    bus.matrix_B = b;
    @(posedge clk);
    #1;
    bus.matrix_A = rand_mat(1'b0);
    bus.matrix_B = rand_mat(1'b0);
    ready_idx = 0;
    ready_cnt = 0;
    busy_cnt  = 0;
    timed_out = 1'b1;
    res       = '0;
    for (int idx = 1; idx <= LIMIT; idx++) begin
      bus.start = (idx == repulse_at);
      if (chk_hold && idx == 1) check_mat("hold_prev_result", bus.result, hold_exp);
      if (bus.busy) busy_cnt++;
      if (bus.result_ready) begin
        ready_cnt++;
        ready_idx = idx;
        res = bus.result;
        if (repulse_done) bus.start = 1'b1;
      end
      if (ready_cnt > 0 && !bus.busy && !bus.result_ready) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.result_ready) ready_cnt++;
    end
  endtask

  task automatic op_and_check(input string name, input matrix_t a, input matrix_t b,
                              input matrix_t exp, input int repulse_at, input bit repulse_done,
                              input bit chk_hold, input matrix_t hold_exp);
    matrix_t res;
    int ri, rc, bc, ec;
    bit to;
    ec = exp_cycles(a);
    run_op(a, b, repulse_at, repulse_done, chk_hold, hold_exp, res, ri, rc, bc, to);
    check({name, ":timeout"}, 64'(to), 64'(0));
    check_mat({name, ":result"}, res, exp);
    check({name, ":ready_idx"}, 64'(ri), 64'(ec + 1));
    check({name, ":ready_cnt"}, 64'(rc), 64'(1));
    check({name, ":busy_cycles"}, 64'(bc), 64'(ec + 1));
    check({name, ":compute_cycles"}, 64'(bus.compute_cycles), 64'(ec));
    check({name, ":state_idle"}, 64'(dbg_state), 64'(IDLE));
    check_mat({name, ":result_held"}, bus.result, exp);
  endtask

  initial begin
    matrix_t a, b, a2, b2, r1, ones, zero;
    int rdy;
    bit seen;

    bus.start    = 1'b0;
    bus.matrix_A = '0;
    bus.matrix_B = '0;
    zero = '0;

    // Clock/reset block
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_result", 64'(bus.result != '0), 64'(0));
    check("rst_ready", 64'(bus.result_ready), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_cycles", 64'(bus.compute_cycles), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_start", 64'(bus.busy), 64'(0));

    // Directed vector table with hand-derived expectations
    for (int v = 0; v < 4; v++) begin
      vecs[v].a = '0;
      vecs[v].b = '0;
      vecs[v].exp = '0;
    end
    vecs[0].name = "identity";
    vecs[1].name = "ones";
    vecs[2].name = "diag";
    vecs[3].name = "overflow";
    for (int e = 0; e < LEN; e++) begin
      vecs[0].b[e]   = WIDTH'(e);
      vecs[0].exp[e] = WIDTH'(e);
      vecs[1].a[e]   = 1;
      vecs[1].b[e]   = 1;
      vecs[1].exp[e] = WIDTH'(N);
      vecs[2].b[e]   = WIDTH'(e);
      vecs[2].exp[e] = WIDTH'(5 * (e / N) * e);
    end
    for (int r = 0; r < N; r++) begin
      vecs[0].a[r*N+r] = 1;
      vecs[2].a[r*N+r] = WIDTH'(5 * r);
    end
    vecs[3].a[0] = 32'h8000_0000;
    vecs[3].b[0] = 32'h8000_0000;
    for (int v = 0; v < 4; v++)
      op_and_check(vecs[v].name, vecs[v].a, vecs[v].b, vecs[v].exp, 0, 1'b0, 1'b0, zero);

    // start re-pulsed in MAC cycle 10 and in the DONE cycle must be ignored
    ones = vecs[1].exp;
    op_and_check("repulse", vecs[2].a, vecs[2].b, vecs[2].exp, 10, 1'b1, 1'b0, zero);
    op_and_check("after_repulse", vecs[1].a, vecs[1].b, ones, 0, 1'b0, 1'b0, zero);

    // rst at MAC cycle 20: everything back to reset values, no completion pulse
    @(negedge clk);
    bus.start    = 1'b1;
    bus.matrix_A = vecs[0].a;
    bus.matrix_B = vecs[0].b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_result", 64'(bus.result != '0), 64'(0));
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    rdy = 0;
    repeat (80) begin
      if (bus.result_ready) rdy++;
      @(posedge clk);
      #1;
    end
    check("midrst_no_ready", 64'(rdy), 64'(0));
    op_and_check("after_rst", vecs[2].a, vecs[2].b, vecs[2].exp, 0, 1'b0, 1'b0, zero);

    // Back-to-back with different operands; first result holds until overwritten
    a  = rand_mat(1'b1);
    b  = rand_mat(1'b0);
    a2 = rand_mat(1'b1);
    b2 = rand_mat(1'b0);
    r1 = ref_mm(a, b);
    op_and_check("b2b_first", a, b, r1, 0, 1'b0, 1'b0, zero);
    op_and_check("b2b_second", a2, b2, ref_mm(a2, b2), 0, 1'b0, 1'b1, r1);

    // Random operations against the reference model
    for (int t = 0; t < 6; t++) begin
      a = rand_mat(t % 2 == 0);
      b = rand_mat(1'b0);
      op_and_check($sformatf("rand%0d", t), a, b, ref_mm(a, b), 0, 1'b0, 1'b0, zero);
    end

    seen = (total > 0);
    if (!seen) bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
